lcd_cmd_queue: RTL and testbench

Command sequencer in front of `LCD_CTRL`. The host pushes 3-bit image commands into a small FIFO through a valid/ready port. The block issues them to `LCD_CTRL` one at a time using the controller's `cmd`/`cmd_valid`/`busy` handshake. It also watches for a stalled controller and reports when the final WRITE command has completed.

---
 rtl/lcd_cmd_queue.sv | 172 +++++++++++++++++
 tb/tb_lcd_cmd_queue.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_queue.sv
// Command FIFO plus issue sequencer in front of LCD_CTRL.
// Hands queued commands to the controller one at a time, flags a stalled controller and latches WRITE completion.
module lcd_cmd_queue #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    host_cmd,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          busy,
   input  logic          done,
   output logic [2:0]    cmd,
   output logic          cmd_valid,
   output logic [AW:0]   fifo_level,
   output logic [7:0]    issued_cnt,
   output logic          timeout_err,
   output logic          seq_done
);

   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_IDLE = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      mem_q [DEPTH];
   logic [2:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [2:0]      cmd_q, cmd_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [7:0]      issued_cnt_q, issued_cnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            seq_done_q, seq_done_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            push_s, pop_s, is_write_s;

   assign host_ready  = (count_q != FULL_LVL) && !seq_done_q;
   assign push_s      = host_valid && host_ready;
   assign is_write_s  = (cmd_q == 3'd0);

   assign cmd         = cmd_q;
   assign cmd_valid   = cmd_valid_q;
   assign fifo_level  = count_q;
   assign issued_cnt  = issued_cnt_q;
   assign timeout_err = timeout_err_q;
   assign seq_done    = seq_done_q;

   // Sequencer: next state, pop request and the registered issue outputs
   always_comb begin
      state_d       = state_q;
      pop_s         = 1'b0;
      cmd_d         = cmd_q;
      timer_d       = timer_q;
      issued_cnt_d  = issued_cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         S_IDLE: begin
            if (!busy && (count_q != '0)) begin
               state_d = S_ISSUE;
               pop_s   = 1'b1;
               cmd_d   = mem_q[rd_ptr_q];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
            timer_d = '0;
            if (issued_cnt_q != 8'd255) begin
               issued_cnt_d = issued_cnt_q + 8'd1;
            end else begin
               issued_cnt_d = issued_cnt_q;
            end
         end
         S_WAIT_BUSY: begin
            if (busy) begin
               state_d = S_WAIT_IDLE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // controller never acknowledged: drop the command and carry on
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1'b1);
            end
         end
         S_WAIT_IDLE: begin
            if (done && is_write_s) begin
               state_d = S_FINISH;
            end else if (!busy) begin
               state_d = is_write_s ? S_WAIT_DONE : S_IDLE;
            end else begin
               state_d = S_WAIT_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (done) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         S_FINISH: begin
            state_d = S_FINISH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      cmd_valid_d = (state_d == S_ISSUE);
      seq_done_d  = seq_done_q || (state_d == S_FINISH);
   end

   // FIFO storage, pointers and occupancy
   always_comb begin
      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = host_cmd;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW + 1)'(1'b1);
         2'b01:   count_d = count_q - (AW + 1)'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 3'd0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         cmd_q         <= 3'd0;
         cmd_valid_q   <= 1'b0;
         issued_cnt_q  <= 8'd0;
         timeout_err_q <= 1'b0;
         seq_done_q    <= 1'b0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         cmd_q         <= cmd_d;
         cmd_valid_q   <= cmd_valid_d;
         issued_cnt_q  <= issued_cnt_d;
         timeout_err_q <= timeout_err_d;
         seq_done_q    <= seq_done_d;
         timer_q       <= timer_d;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Randomised bench for lcd_cmd_queue: LCD_CTRL responder, queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_lcd_cmd_queue;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    host_cmd = 3'd0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          busy = 1'b1;
   logic          done = 1'b0;
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic [AW:0]   fifo_level;
   logic [7:0]    issued_cnt;
   logic          timeout_err;
   logic          seq_done;

   lcd_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(rst_n), .host_cmd(host_cmd), .host_valid(host_valid),
      .host_ready(host_ready), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
      .fifo_level(fifo_level), .issued_cnt(issued_cnt), .timeout_err(timeout_err),
      .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- LCD_CTRL responder ----------------
   bit  load_busy = 1'b1;
   bit  ctrl_busy = 1'b0;
   bit  no_rise5  = 1'b0;
   bit  rand_drop = 1'b0;
   bit  fix_rise  = 1'b0;
   int  fix_blen  = 0;
   int  rise_cnt = 0, hi_cnt = 0, done_cnt = 0, blen = 1;
   bit  resp_wr = 1'b0;

   initial begin
      forever begin
         @(posedge clk); #1;
         done = 1'b0;
         if (!rst_n) begin
            rise_cnt = 0; hi_cnt = 0; done_cnt = 0; ctrl_busy = 1'b0;
         end else begin
            if (rise_cnt > 0) begin
               rise_cnt--;
               if (rise_cnt == 0) begin ctrl_busy = 1'b1; hi_cnt = blen; end
            end else if (hi_cnt > 0) begin
               hi_cnt--;
               if (hi_cnt == 0) begin ctrl_busy = 1'b0; if (resp_wr) done_cnt = 3; end
            end else if (done_cnt > 0) begin
               done_cnt--;
               if (done_cnt == 0) done = 1'b1;
            end
            if (cmd_valid) begin
               resp_wr = (cmd == 3'd0);
               blen    = (fix_blen != 0) ? fix_blen : int'($urandom_range(1, 4));
               if (no_rise5 && cmd == 3'd5) rise_cnt = 0;
               else if (rand_drop && cmd != 3'd0 && $urandom_range(0, 7) == 0) rise_cnt = 0;
               else rise_cnt = fix_rise ? 1 : int'($urandom_range(1, 3));
            end
         end
         busy = load_busy || ctrl_busy;
      end
   end

   // ---------------- reference model ----------------
   int  mq[$];
   bit  m_fin = 1'b0, m_tmo = 1'b0, m_strobe = 1'b0, o_wr = 1'b0;
   int  m_cnt = 0, m_cmd = 0;
   int  o_phase = 0;   // 0 nothing outstanding, 1 awaiting busy, 2 awaiting release, 3 awaiting done
   int  o_age = 0;

   initial begin
      forever begin
         bit pushing, was_strobe;
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete(); m_fin = 1'b0; m_tmo = 1'b0; m_strobe = 1'b0;
            m_cnt = 0; m_cmd = 0; o_phase = 0; o_age = 0; o_wr = 1'b0;
         end else begin
            pushing    = host_valid && (mq.size() != DEPTH) && !m_fin;
            was_strobe = m_strobe;
            m_strobe   = 1'b0;
            if (!m_fin) begin
               if (was_strobe) begin
                  o_phase = 1; o_age = 0;
                  if (m_cnt < 255) m_cnt++;
               end else if (o_phase == 1) begin
                  if (busy) o_phase = 2;
                  else if (o_age == TIMEOUT - 1) begin m_tmo = 1'b1; o_phase = 0; end
                  else o_age++;
               end else if (o_phase == 2) begin
                  if (o_wr && done) m_fin = 1'b1;
                  else if (!busy) o_phase = o_wr ? 3 : 0;
               end else if (o_phase == 3) begin
                  if (done) m_fin = 1'b1;
               end else if (!busy && mq.size() > 0) begin
                  m_cmd = mq.pop_front(); o_wr = (m_cmd == 0); m_strobe = 1'b1;
               end
            end
            if (pushing) mq.push_back(int'(host_cmd));
         end
      end
   end

   // ---------------- per-cycle compare and observation ----------------
   int  obs[$];
   int  obs_cyc[$];
   int  strobes = 0;
   bit  tmo_seen = 1'b0;
   int  tmo_cyc = 0;

   initial forever begin
      @(posedge clk); cyc++;
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cmd_valid", int'(cmd_valid), int'(m_strobe));
         chk("cmd", int'(cmd), m_cmd);
         chk("fifo_level", int'(fifo_level), mq.size());
         chk("host_ready", int'(host_ready), int'((mq.size() != DEPTH) && !m_fin));
         chk("issued_cnt", int'(issued_cnt), m_cnt);
         chk("timeout_err", int'(timeout_err), int'(m_tmo));
         chk("seq_done", int'(seq_done), int'(m_fin));
         if (cmd_valid) begin obs.push_back(int'(cmd)); obs_cyc.push_back(cyc); strobes++; end
         if (timeout_err && !tmo_seen) begin tmo_seen = 1'b1; tmo_cyc = cyc; end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic push(input int c);
      host_valid = 1'b1; host_cmd = 3'(c);
      tick();
      host_valid = 1'b0;
   endtask

   task automatic clear_obs();
      obs.delete(); obs_cyc.delete();
   endtask

   function automatic int obs_at(input int i);
      if (i < obs.size()) return obs[i];
      return -1;
   endfunction

   task automatic do_reset();
      host_valid = 1'b0; load_busy = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tmo_seen = 1'b0;
      clear_obs();
      tick();
   endtask

   task automatic wait_obs(input int n, input int budget, input string name);
      int k = 0;
      while (obs.size() < n && k < budget) begin tick(); k++; end
      chk(name, int'(obs.size() >= n), 1);
   endtask

   task automatic wait_fin(input int budget, input string name);
      int k = 0;
      while (!seq_done && k < budget) begin tick(); k++; end
      chk(name, int'(seq_done), 1);
   endtask

   initial begin
      int pushed[$];
      int c, n;

      // S1: commands queued during IROM load, issued in order, WRITE ends the sequence
      do_reset();
      push(1); push(3); push(0);
      repeat (67) tick();
      chk("s1_no_issue_while_busy", obs.size(), 0);
      chk("s1_level", int'(fifo_level), 3);
      load_busy = 1'b0;
      wait_fin(300, "s1_wait_done");
      chk("s1_count", obs.size(), 3);
      chk("s1_order0", obs_at(0), 1);
      chk("s1_order1", obs_at(1), 3);
      chk("s1_order2", obs_at(2), 0);
      chk("s1_issued_cnt", int'(issued_cnt), 3);
      chk("s1_host_ready", int'(host_ready), 0);
      n = strobes;
      for (int i = 0; i < 10; i++) push(int'($urandom_range(1, 7)));
      repeat (10) tick();
      chk("s1_no_issue_after_finish", strobes - n, 0);
      chk("s1_level_after_finish", int'(fifo_level), 0);

      // S2: fill to full, overflow push ignored, drain preserves order
      do_reset();
      for (int i = 0; i < 9; i++) begin
         c = int'($urandom_range(1, 7));
         if (i < 8) pushed.push_back(c);
         if (i == 8) begin
            chk("s2_full_level", int'(fifo_level), 8);
            chk("s2_full_ready", int'(host_ready), 0);
         end
         push(c);
      end
      chk("s2_overflow_level", int'(fifo_level), 8);
      load_busy = 1'b0;
      wait_obs(8, 300, "s2_drain");
      repeat (30) tick();
      chk("s2_issue_count", obs.size(), 8);
      for (int i = 0; i < 8; i++) chk("s2_order", obs_at(i), pushed[i]);
      clear_obs(); pushed.delete();
      for (int i = 0; i < 6; i++) begin
         c = int'($urandom_range(1, 7)); pushed.push_back(c); push(c);
      end
      wait_obs(6, 300, "s2_wrap_drain");
      for (int i = 0; i < 6; i++) chk("s2_wrap_order", obs_at(i), pushed[i]);

      // S3: simultaneous push and pop at level 4
      repeat (20) tick();
      load_busy = 1'b1;
      tick();
      clear_obs(); pushed.delete();
      for (int i = 0; i < 4; i++) begin
         c = int'($urandom_range(1, 7)); pushed.push_back(c); push(c);
      end
      load_busy = 1'b0;
      tick();
      c = int'($urandom_range(1, 7)); pushed.push_back(c);
      host_valid = 1'b1; host_cmd = 3'(c);
      tick();
      host_valid = 1'b0;
      chk("s3_level_kept", int'(fifo_level), 4);
      chk("s3_strobe", int'(cmd_valid), 1);
      chk("s3_head", int'(cmd), pushed[0]);
      wait_obs(5, 200, "s3_drain");
      for (int i = 0; i < 5; i++) chk("s3_order", obs_at(i), pushed[i]);

      // S4: controller ignores AVERAGE; timeout then next command still issues
      do_reset();
      no_rise5 = 1'b1;
      push(5); push(2);
      load_busy = 1'b0;
      wait_obs(2, 150, "s4_second_issue");
      chk("s4_timeout_flag", int'(timeout_err), 1);
      chk("s4_timeout_delay", tmo_seen ? (tmo_cyc - obs_cyc[0]) : -1, 16);
      chk("s4_first", obs_at(0), 5);
      chk("s4_second", obs_at(1), 2);
      repeat (15) tick();
      no_rise5 = 1'b0;

      // S5: random traffic with occasional dropped acknowledges, then WRITE
      do_reset();
      load_busy = 1'b0;
      rand_drop = 1'b1;
      for (int i = 0; i < 600; i++) begin
         host_valid = ($urandom_range(0, 2) == 0);
         host_cmd   = 3'($urandom_range(1, 7));
         tick();
      end
      host_valid = 1'b0;
      push(0);
      wait_fin(400, "s5_wait_done");
      n = strobes;
      for (int i = 0; i < 20; i++) push(int'($urandom_range(0, 7)));
      chk("s5_no_issue_after_finish", strobes - n, 0);
      chk("s5_host_ready", int'(host_ready), 0);
      rand_drop = 1'b0;

      // S6: reset while waiting for busy to fall with 5 entries queued
      do_reset();
      fix_blen = 10; fix_rise = 1'b1;
      for (int i = 0; i < 6; i++) push(int'($urandom_range(1, 7)));
      load_busy = 1'b0;
      wait_obs(1, 50, "s6_first_issue");
      tick();
      chk("s6_level_before", int'(fifo_level), 5);
      load_busy = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("s6_cmd_valid", int'(cmd_valid), 0);
      chk("s6_cmd", int'(cmd), 0);
      chk("s6_level", int'(fifo_level), 0);
      chk("s6_issued", int'(issued_cnt), 0);
      chk("s6_timeout", int'(timeout_err), 0);
      chk("s6_seq_done", int'(seq_done), 0);
      chk("s6_host_ready", int'(host_ready), 1);
      repeat (2) tick();
      rst_n = 1'b1;
      fix_blen = 0; fix_rise = 1'b0;
      tick();
      clear_obs();
      push(4); push(6);
      load_busy = 1'b0;
      wait_obs(2, 100, "s6_resume");
      chk("s6_resume0", obs_at(0), 4);
      chk("s6_resume1", obs_at(1), 6);
      repeat (10) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
